// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcode constants,
// main-control state encoding and datapath mux/mode encodings. The ALU decoder
// imports the same package so the alu_mode encoding stays consistent.
package mips;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] ALUop   = 6'd0;
    localparam logic [5:0] Jop     = 6'd2;
    localparam logic [5:0] JALop   = 6'd3;
    localparam logic [5:0] BEQop   = 6'd4;
    localparam logic [5:0] ADD_IMM = 6'd8;
    localparam logic [5:0] LW      = 6'd35;
    localparam logic [5:0] SW      = 6'd43;

    // Main control states
    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_ADDIEX,
        S_ADDIWB,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_JUMP,
        S_ERR
    } state_t;

    // PC source select
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // Register file destination select
    localparam logic [1:0] REG_DST_RT = 2'b00;
    localparam logic [1:0] REG_DST_RD = 2'b01;
    localparam logic [1:0] REG_DST_RA = 2'b10;

    // Register file write-back source select
    localparam logic [1:0] WB_SEL_ALUOUT = 2'b00;
    localparam logic [1:0] WB_SEL_MDR    = 2'b01;
    localparam logic [1:0] WB_SEL_PC     = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRC_B_REG      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR     = 2'b01;
    localparam logic [1:0] SRC_B_IMM      = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

    // ALU mode handed to the ALU decoder
    localparam logic [1:0] ALU_MODE_ADD   = 2'b00;
    localparam logic [1:0] ALU_MODE_SUB   = 2'b01;
    localparam logic [1:0] ALU_MODE_FUNCT = 2'b10;

endpackage

// File: rtl/mips_perf_counter.sv
// Retired-instruction and cycle counter pair for the main control FSM.
// Both counters wrap modulo 2^CNT_W and clear on reset.
module mips_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             retire,
    input  logic             run,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
);

    // Count completed instructions and non-halted cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired <= '0;
            cycles  <= '0;
        end else begin
            if (retire) begin
                retired <= retired + 1'b1;
            end
            if (run) begin
                cycles <= cycles + 1'b1;
            end
        end
    end

endmodule

// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle MIPS core. Sequences fetch, decode,
// execute, memory and write-back, drives datapath enables/mux selects and
// the alu_mode hint for the ALU decoder. Memory accesses may be stretched by
// mem_ready; a wait longer than MEM_TIMEOUT cycles, or an unknown opcode,
// parks the FSM in a sticky halt state until reset.
// Optional feature: define PERF_CNT_EN to add the retired/cycles counters.
module multicycle_main_control
    import mips::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_mode,
    output logic       halted
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
`endif
);

    // Wait counter value on the last tolerated wait cycle; the next edge halts.
    localparam logic [7:0] WAIT_LIMIT = 8'(MEM_TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       timeout;

    assign timeout = (wait_cnt == WAIT_LIMIT);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Consecutive memory wait cycles; restarts whenever the state changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if (mem_req && !mem_ready) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Next-state and Moore-style output decode; everything forced low during reset
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = PC_SRC_ALU;
        reg_we     = 1'b0;
        reg_dst    = REG_DST_RT;
        wb_sel     = WB_SEL_ALUOUT;
        alu_src_a  = 1'b0;
        alu_src_b  = SRC_B_REG;
        alu_mode   = ALU_MODE_ADD;
        halted     = 1'b0;

        if (!rst) begin
            case (state)
                S_FETCH: begin
                    // PC + 4 computed in parallel with the instruction read
                    mem_req   = 1'b1;
                    alu_src_b = SRC_B_FOUR;
                    if (mem_ready) begin
                        ir_we      = 1'b1;
                        pc_we      = 1'b1;
                        state_next = S_DECODE;
                    end else if (timeout) begin
                        state_next = S_ERR;
                    end
                end
                S_DECODE: begin
                    // Speculatively form the branch target into ALUOut
                    alu_src_b = SRC_B_IMM_SHL2;
                    case (op)
                        LW, SW:  state_next = S_MEMADR;
                        ADD_IMM: state_next = S_ADDIEX;
                        ALUop:   state_next = S_EXEC;
                        BEQop:   state_next = S_BRANCH;
                        Jop,
                        JALop:   state_next = S_JUMP;
                        default: state_next = S_ERR;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRC_B_IMM;
                    state_next = (op == LW) ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    // MDR captures the read data; IR must stay untouched
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_next = S_MEMWB;
                    end else if (timeout) begin
                        state_next = S_ERR;
                    end
                end
                S_MEMWB: begin
                    reg_we     = 1'b1;
                    reg_dst    = REG_DST_RT;
                    wb_sel     = WB_SEL_MDR;
                    state_next = S_FETCH;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    iord    = 1'b1;
                    if (mem_ready) begin
                        state_next = S_FETCH;
                    end else if (timeout) begin
                        state_next = S_ERR;
                    end
                end
                S_ADDIEX: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRC_B_IMM;
                    state_next = S_ADDIWB;
                end
                S_ADDIWB: begin
                    reg_we     = 1'b1;
                    reg_dst    = REG_DST_RT;
                    wb_sel     = WB_SEL_ALUOUT;
                    state_next = S_FETCH;
                end
                S_EXEC: begin
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRC_B_REG;
                    alu_mode   = ALU_MODE_FUNCT;
                    state_next = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_we     = 1'b1;
                    reg_dst    = REG_DST_RD;
                    wb_sel     = WB_SEL_ALUOUT;
                    state_next = S_FETCH;
                end
                S_BRANCH: begin
                    // Compare A - B; take the ALUOut target only when equal
                    alu_src_a  = 1'b1;
                    alu_src_b  = SRC_B_REG;
                    alu_mode   = ALU_MODE_SUB;
                    pc_src     = PC_SRC_ALUOUT;
                    pc_we      = zero;
                    state_next = S_FETCH;
                end
                S_JUMP: begin
                    // PC already holds the return address (PC + 4) for JAL
                    pc_we  = 1'b1;
                    pc_src = PC_SRC_JUMP;
                    if (op == JALop) begin
                        reg_we  = 1'b1;
                        reg_dst = REG_DST_RA;
                        wb_sel  = WB_SEL_PC;
                    end
                    state_next = S_FETCH;
                end
                default: begin
                    // S_ERR: absorbing until reset
                    halted     = 1'b1;
                    state_next = S_ERR;
                end
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic retire;
    logic run;

    assign retire = (state != S_FETCH) && (state_next == S_FETCH);
    assign run    = (state != S_ERR);

    mips_perf_counter #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk    (clk),
        .rst    (rst),
        .retire (retire),
        .run    (run),
        .retired(retired),
        .cycles (cycles)
    );
`endif

endmodule

// File: tb/tb_multicycle_main_control.sv
// Self-checking bench for multicycle_main_control (MEM_TIMEOUT = 4).
// Each test queues per-cycle stimulus with the expected output vector; the
// expectation is pushed to a scoreboard when the stimulus is driven and
// popped at the falling edge for comparison.
module tb_multicycle_main_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_we, pc_we, reg_we, alu_src_a, halted;
    logic [1:0] pc_src, reg_dst, wb_sel, alu_src_b, alu_mode;
`ifdef PERF_CNT_EN
    logic [31:0] retired, cycles;
`endif

    always #5 clk = ~clk;

    multicycle_main_control #(
        .MEM_TIMEOUT(4),
        .CNT_W      (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .zero     (zero),
        .mem_ready(mem_ready),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .iord     (iord),
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .pc_src   (pc_src),
        .reg_we   (reg_we),
        .reg_dst  (reg_dst),
        .wb_sel   (wb_sel),
        .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b),
        .alu_mode (alu_mode),
        .halted   (halted)
`ifdef PERF_CNT_EN
        ,
        .retired  (retired),
        .cycles   (cycles)
`endif
    );

    logic [17:0] obs;
    assign obs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, reg_we, reg_dst,
                  wb_sel, alu_src_a, alu_src_b, alu_mode, halted};

    typedef struct packed {
        logic [5:0]  op;
        logic        zero;
        logic        rdy;
        logic [17:0] exp;
    } step_t;

    step_t       steps[$];
    logic [17:0] exp_q[$];
    int          total = 0;
    int          bad = 0;

    logic [17:0] E_FETCH, E_FETCH_W, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_MEMWR;
    logic [17:0] E_ADDIWB, E_EXEC, E_ALUWB, E_BR_T, E_BR_N, E_J, E_JAL, E_ERR;

    function automatic logic [17:0] ov(input logic req, input logic we, input logic ad,
                                       input logic irw, input logic pcw, input logic [1:0] psrc,
                                       input logic rw, input logic [1:0] rdst, input logic [1:0] wsel,
                                       input logic sa, input logic [1:0] sb, input logic [1:0] mode,
                                       input logic h);
        return {req, we, ad, irw, pcw, psrc, rw, rdst, wsel, sa, sb, mode, h};
    endfunction

    task automatic add(input logic [5:0] o, input logic z, input logic r, input logic [17:0] e);
        steps.push_back('{o, z, r, e});
    endtask

    task automatic drive(input step_t s);
        op        = s.op;
        zero      = s.zero;
        mem_ready = s.rdy;
        exp_q.push_back(s.exp);
    endtask

    // Leaves the DUT in FETCH just after a rising edge
    task automatic apply_reset();
        rst = 1'b1;
        op = 6'd0;
        zero = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [17:0] e;
        rst = 1'b1;
        mem_ready = 1'b1;
        op = 6'd35;
        exp_q.push_back(18'd0);
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL reset_outputs: got %h want %h", obs, e);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        mem_ready = 1'b0;
        exp_q.push_back(E_FETCH_W);
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL reset_release_fetch: got %h want %h", obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_lw();
        logic [17:0] e;
        int n = 0;
        apply_reset();
        add(6'd35, 1'b0, 1'b1, E_FETCH);
        add(6'd35, 1'b0, 1'b1, E_DECODE);
        add(6'd35, 1'b0, 1'b1, E_MEMADR);
        add(6'd35, 1'b0, 1'b1, E_MEMRD);
        add(6'd35, 1'b0, 1'b1, E_MEMWB);
        add(6'd0,  1'b0, 1'b0, E_FETCH_W);
        while (steps.size() > 0) begin
            drive(steps.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            n++;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL lw cycle %0d: got %h want %h", n, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch_jump_addi();
        logic [17:0] e;
        int n = 0;
        apply_reset();
        // BEQ taken
        add(6'd4, 1'b1, 1'b1, E_FETCH);
        add(6'd4, 1'b1, 1'b1, E_DECODE);
        add(6'd4, 1'b1, 1'b1, E_BR_T);
        // BEQ not taken
        add(6'd4, 1'b0, 1'b1, E_FETCH);
        add(6'd4, 1'b0, 1'b1, E_DECODE);
        add(6'd4, 1'b0, 1'b1, E_BR_N);
        // J (no link)
        add(6'd2, 1'b0, 1'b1, E_FETCH);
        add(6'd2, 1'b0, 1'b1, E_DECODE);
        add(6'd2, 1'b0, 1'b1, E_J);
        // ADDI
        add(6'd8, 1'b0, 1'b1, E_FETCH);
        add(6'd8, 1'b0, 1'b1, E_DECODE);
        add(6'd8, 1'b0, 1'b1, E_MEMADR);
        add(6'd8, 1'b0, 1'b1, E_ADDIWB);
        add(6'd8, 1'b0, 1'b0, E_FETCH_W);
        while (steps.size() > 0) begin
            drive(steps.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            n++;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL beq_j_addi cycle %0d: got %h want %h", n, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_fetch_wait();
        logic [17:0] e;
        int n = 0;
        apply_reset();
        add(6'd0, 1'b0, 1'b0, E_FETCH_W);
        add(6'd0, 1'b0, 1'b0, E_FETCH_W);
        add(6'd0, 1'b0, 1'b0, E_FETCH_W);
        add(6'd0, 1'b0, 1'b1, E_FETCH);
        add(6'd0, 1'b0, 1'b0, E_DECODE);
        add(6'd0, 1'b0, 1'b0, E_EXEC);
        add(6'd0, 1'b0, 1'b0, E_ALUWB);
        add(6'd0, 1'b0, 1'b0, E_FETCH_W);
        while (steps.size() > 0) begin
            drive(steps.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            n++;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL fetch_wait cycle %0d: got %h want %h", n, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_timeout();
        logic [17:0] e;
        int n = 0;
        apply_reset();
        add(6'd43, 1'b0, 1'b1, E_FETCH);
        add(6'd43, 1'b0, 1'b1, E_DECODE);
        add(6'd43, 1'b0, 1'b1, E_MEMADR);
        for (int i = 0; i < 4; i++) add(6'd43, 1'b0, 1'b0, E_MEMWR);
        add(6'd43, 1'b0, 1'b0, E_ERR);
        add(6'd35, 1'b0, 1'b1, E_ERR);
        add(6'd0,  1'b1, 1'b1, E_ERR);
        while (steps.size() > 0) begin
            drive(steps.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            n++;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL sw_timeout cycle %0d: got %h want %h", n, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_illegal();
        logic [17:0] e;
        int n = 0;
        apply_reset();
        add(6'd63, 1'b0, 1'b1, E_FETCH);
        add(6'd63, 1'b0, 1'b1, E_DECODE);
        add(6'd63, 1'b0, 1'b1, E_ERR);
        add(6'd4,  1'b1, 1'b1, E_ERR);
        while (steps.size() > 0) begin
            drive(steps.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            n++;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL illegal_op cycle %0d: got %h want %h", n, obs, e);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_rst_mid_memrd();
        logic [17:0] e;
        int n = 0;
        apply_reset();
        add(6'd35, 1'b0, 1'b1, E_FETCH);
        add(6'd35, 1'b0, 1'b1, E_DECODE);
        add(6'd35, 1'b0, 1'b1, E_MEMADR);
        add(6'd35, 1'b0, 1'b0, E_MEMRD);
        while (steps.size() > 0) begin
            drive(steps.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            n++;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL rst_mid_memrd cycle %0d: got %h want %h", n, obs, e);
            end
            @(posedge clk);
            #1;
        end
        // Still in MEMRD waiting; pulse reset between clock edges
        #2;
        rst = 1'b1;
        exp_q.push_back(18'd0);
        #1;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL rst_async_outputs: got %h want %h", obs, e);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.push_back(E_FETCH_W);
        @(negedge clk);
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
            bad++;
            $display("FAIL rst_back_to_fetch: got %h want %h", obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [17:0] e;
        int n = 0;
        apply_reset();
        // R-type
        add(6'd0, 1'b0, 1'b1, E_FETCH);
        add(6'd0, 1'b0, 1'b1, E_DECODE);
        add(6'd0, 1'b0, 1'b1, E_EXEC);
        add(6'd0, 1'b0, 1'b1, E_ALUWB);
        // JAL
        add(6'd3, 1'b0, 1'b1, E_FETCH);
        add(6'd3, 1'b0, 1'b1, E_DECODE);
        add(6'd3, 1'b0, 1'b1, E_JAL);
        // SW
        add(6'd43, 1'b0, 1'b1, E_FETCH);
        add(6'd43, 1'b0, 1'b1, E_DECODE);
        add(6'd43, 1'b0, 1'b1, E_MEMADR);
        add(6'd43, 1'b0, 1'b1, E_MEMWR);
        while (steps.size() > 0) begin
            drive(steps.pop_front());
            @(negedge clk);
            e = exp_q.pop_front();
            n++;
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL back_to_back cycle %0d: got %h want %h", n, obs, e);
            end
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b0;
`ifdef PERF_CNT_EN
        total++;
        if (retired !== 32'd3) begin
            bad++;
            $display("FAIL perf_retired: got %0d want 3", retired);
        end
        total++;
        if (cycles !== 32'd11) begin
            bad++;
            $display("FAIL perf_cycles: got %0d want 11", cycles);
        end
`endif
    endtask

    initial begin
        E_FETCH   = ov(1, 0, 0, 1, 1, 2'b00, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0);
        E_FETCH_W = ov(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 0);
        E_DECODE  = ov(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b11, 2'b00, 0);
        E_MEMADR  = ov(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b10, 2'b00, 0);
        E_MEMRD   = ov(1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        E_MEMWB   = ov(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b01, 0, 2'b00, 2'b00, 0);
        E_MEMWR   = ov(1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        E_ADDIWB  = ov(0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        E_EXEC    = ov(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 2'b00, 2'b10, 0);
        E_ALUWB   = ov(0, 0, 0, 0, 0, 2'b00, 1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 0);
        E_BR_T    = ov(0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 0);
        E_BR_N    = ov(0, 0, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 1, 2'b00, 2'b01, 0);
        E_J       = ov(0, 0, 0, 0, 1, 2'b10, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 0);
        E_JAL     = ov(0, 0, 0, 0, 1, 2'b10, 1, 2'b10, 2'b10, 0, 2'b00, 2'b00, 0);
        E_ERR     = ov(0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 1);

        #2;
        test_reset();
        test_lw();
        test_branch_jump_addi();
        test_fetch_wait();
        test_timeout();
        test_illegal();
        test_rst_mid_memrd();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
